// File: rtl/fifo_pkg.sv
// Shared pointer types and Gray-code conversions for the asynchronous FIFO.
// Conversions work on a 32-bit word so that any pointer width up to 32 bits can use them.
`timescale 1ns/1ps
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;

  typedef logic [FIFO_ADDR_WIDTH:0]   ptr_t;
  typedef logic [FIFO_ADDR_WIDTH-1:0] addr_t;
  typedef logic [31:0]                word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray input yields the correct binary value in the low bits
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_sync.sv
// Multi-flop synchronizer chain bringing a Gray pointer into the write clock domain.
`timescale 1ns/1ps
module sync_nff #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full, overflow and pessimistic fill level of the async FIFO.
`timescale 1ns/1ps
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   wr_level
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] wbin_reg,  wbin_next;
  logic [PW-1:0] wgray_reg, wgray_next;
  logic [PW-1:0] level_reg, level_next;
  logic          full_reg,  full_next;
  logic          af_reg,    af_next;
  logic          ovf_reg,   ovf_next;
  logic          accept;

  sync_nff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rptr_gray_async),
    .q     (rq_sync)
  );

  assign accept     = wr_en & ~full_reg;
  assign wbin_next  = wbin_reg + PW'(accept);
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));

  // Full when the write pointer sits exactly one lap ahead of the synchronized read pointer
  assign full_cmp   = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
  assign full_next  = (wgray_next == full_cmp);

  // Stale read pointer makes this an over-estimate of the real occupancy
  assign rbin_sync  = PW'(gray2bin(32'(rq_sync)));
  assign level_next = wbin_next - rbin_sync;
  assign af_next    = (level_next >= AF_THRESH);
  assign ovf_next   = wr_en & full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_reg  <= '0;
      wgray_reg <= '0;
      level_reg <= '0;
      full_reg  <= 1'b0;
      af_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      wbin_reg  <= wbin_next;
      wgray_reg <= wgray_next;
      level_reg <= level_next;
      full_reg  <= full_next;
      af_reg    <= af_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign mem_we      = accept;
  assign waddr       = wbin_reg[ADDR_WIDTH-1:0];
  assign wptr_gray   = wgray_reg;
  assign full        = full_reg;
  assign almost_full = af_reg;
  assign overflow    = ovf_reg;
  assign wr_level    = level_reg;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for the FIFO write-pointer/full stage: inputs change on negedge, outputs sampled on negedge.
`timescale 1ns/1ps
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] rptr_gray_async = 5'd0;
  logic       mem_we;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic [4:0] wr_level;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [4:0] prev_gray = 5'd0;

  // Gray codes of 1..16, worked out by hand
  logic [4:0] gtab [16] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                            5'b00111, 5'b00101, 5'b00100, 5'b01100,
                            5'b01101, 5'b01111, 5'b01110, 5'b01010,
                            5'b01011, 5'b01001, 5'b01000, 5'b11000};

  fifo_wptr_full dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .rptr_gray_async (rptr_gray_async),
    .mem_we          (mem_we),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .almost_full     (almost_full),
    .overflow        (overflow),
    .wr_level        (wr_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] g5(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  // One clock: wait for the next negedge, then check the Gray pointer moved by at most one bit
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      n_cmp++;
      if ($countones(wptr_gray ^ prev_gray) > 1) begin
        n_err++;
        $display("FAIL gray_step got %b prev %b", wptr_gray, prev_gray);
      end
    end
    prev_gray = wptr_gray;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rptr_gray_async = 5'd0;
    tick();
    tick();
    rst_n = 1'b1;
    prev_gray = 5'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    rptr_gray_async = 5'd0;
    tick();
    tick();
    n_cmp++; if (wptr_gray !== 5'd0)  begin n_err++; $display("FAIL reset_gray got %b exp 00000", wptr_gray); end
    n_cmp++; if (waddr !== 4'd0)      begin n_err++; $display("FAIL reset_waddr got %0d exp 0", waddr); end
    n_cmp++; if (full !== 1'b0)       begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got %b exp 0", almost_full); end
    n_cmp++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    n_cmp++; if (wr_level !== 5'd0)   begin n_err++; $display("FAIL reset_level got %0d exp 0", wr_level); end
    n_cmp++; if (mem_we !== 1'b0)     begin n_err++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    rst_n = 1'b1;
    prev_gray = 5'd0;
    $display("test_reset done");
  endtask

  task automatic test_fill();
    wr_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++; if (wptr_gray !== gtab[k-1]) begin n_err++; $display("FAIL fill_gray k=%0d got %b exp %b", k, wptr_gray, gtab[k-1]); end
      n_cmp++; if (int'(wr_level) != k) begin n_err++; $display("FAIL fill_level k=%0d got %0d exp %0d", k, wr_level, k); end
      n_cmp++; if (almost_full !== (k >= 14)) begin n_err++; $display("FAIL fill_af k=%0d got %b exp %b", k, almost_full, k >= 14); end
      n_cmp++; if (full !== (k == 16)) begin n_err++; $display("FAIL fill_full k=%0d got %b exp %b", k, full, k == 16); end
      n_cmp++; if (int'(waddr) != k % 16) begin n_err++; $display("FAIL fill_waddr k=%0d got %0d exp %0d", k, waddr, k % 16); end
      n_cmp++; if (mem_we !== (k < 16)) begin n_err++; $display("FAIL fill_mem_we k=%0d got %b exp %b", k, mem_we, k < 16); end
      $display("fill write %0d: gray=%b level=%0d af=%b full=%b", k, wptr_gray, wr_level, almost_full, full);
    end
  endtask

  task automatic test_overflow();
    wr_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) wr_en = 1'b0;
      tick();
      n_cmp++; if (overflow !== (k <= 2)) begin n_err++; $display("FAIL ovf_pulse k=%0d got %b exp %b", k, overflow, k <= 2); end
      n_cmp++; if (wptr_gray !== 5'b11000) begin n_err++; $display("FAIL ovf_gray k=%0d got %b exp 11000", k, wptr_gray); end
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full k=%0d got %b exp 1", k, full); end
      n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL ovf_mem_we k=%0d got %b exp 0", k, mem_we); end
      $display("overflow cycle %0d: ovf=%b gray=%b", k, overflow, wptr_gray);
    end
  endtask

  task automatic test_full_release();
    wr_en = 1'b0;
    rptr_gray_async = 5'b00001;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (full !== (k < 3)) begin n_err++; $display("FAIL rel_full edge=%0d got %b exp %b", k, full, k < 3); end
      n_cmp++; if (int'(wr_level) != (k < 3 ? 16 : 15)) begin n_err++; $display("FAIL rel_level edge=%0d got %0d exp %0d", k, wr_level, k < 3 ? 16 : 15); end
      n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL rel_af edge=%0d got %b exp 1", k, almost_full); end
      $display("release edge %0d: full=%b level=%0d af=%b", k, full, wr_level, almost_full);
    end
  endtask

  task automatic test_wrap();
    int exp_level;
    apply_reset();
    wr_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      rptr_gray_async = g5((k - 5) > 0 ? (k - 5) : 0);
      tick();
      // Two-stage sync plus a registered level puts the read pointer 7 writes behind
      exp_level = (k < 7) ? k : 7;
      n_cmp++; if (wptr_gray !== g5(k)) begin n_err++; $display("FAIL wrap_gray k=%0d got %b exp %b", k, wptr_gray, g5(k)); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL wrap_full k=%0d got %b exp 0", k, full); end
      n_cmp++; if (int'(wr_level) != exp_level) begin n_err++; $display("FAIL wrap_level k=%0d got %0d exp %0d", k, wr_level, exp_level); end
      n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL wrap_af k=%0d got %b exp 0", k, almost_full); end
      $display("wrap write %0d: gray=%b level=%0d", k, wptr_gray, wr_level);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    wr_en = 1'b1;
    repeat (8) tick();
    wr_en = 1'b0;
    tick();
    n_cmp++; if (wptr_gray !== 5'b01100) begin n_err++; $display("FAIL half_gray got %b exp 01100", wptr_gray); end
    n_cmp++; if (wr_level !== 5'd8) begin n_err++; $display("FAIL half_level got %0d exp 8", wr_level); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (wptr_gray !== 5'd0) begin n_err++; $display("FAIL areset_gray got %b exp 00000", wptr_gray); end
    n_cmp++; if (waddr !== 4'd0) begin n_err++; $display("FAIL areset_waddr got %0d exp 0", waddr); end
    n_cmp++; if (wr_level !== 5'd0) begin n_err++; $display("FAIL areset_level got %0d exp 0", wr_level); end
    n_cmp++; if (full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0) begin
      n_err++; $display("FAIL areset_flags got full=%b af=%b ovf=%b exp 0 0 0", full, almost_full, overflow);
    end
    prev_gray = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL post_reset_mem_we got %b exp 1", mem_we); end
    n_cmp++; if (waddr !== 4'd0) begin n_err++; $display("FAIL post_reset_waddr got %0d exp 0", waddr); end
    tick();
    n_cmp++; if (wptr_gray !== 5'b00001) begin n_err++; $display("FAIL post_reset_gray got %b exp 00001", wptr_gray); end
    n_cmp++; if (waddr !== 4'd1) begin n_err++; $display("FAIL post_reset_waddr2 got %0d exp 1", waddr); end
    n_cmp++; if (wr_level !== 5'd1) begin n_err++; $display("FAIL post_reset_level got %0d exp 1", wr_level); end
    wr_en = 1'b0;
    $display("test_async_reset done: gray=%b level=%0d", wptr_gray, wr_level);
  endtask

  task automatic test_random();
    int   wcnt;
    int   rtrue;
    logic acc;
    apply_reset();
    wcnt  = 0;
    rtrue = 0;
    for (int c = 0; c < 80; c++) begin
      wr_en = (c % 2 == 0);
      if (rtrue < wcnt && $urandom_range(0, 4) == 0) rtrue++;
      rptr_gray_async = g5(rtrue);
      #1;
      acc = mem_we;
      n_cmp++; if (mem_we === 1'b1 && full === 1'b1) begin n_err++; $display("FAIL rnd_write_while_full c=%0d got mem_we=1 full=1", c); end
      tick();
      if (acc === 1'b1) wcnt++;
      n_cmp++; if (int'(wr_level) < wcnt - rtrue) begin n_err++; $display("FAIL rnd_level c=%0d got %0d exp >= %0d", c, wr_level, wcnt - rtrue); end
      n_cmp++; if (int'(waddr) != wcnt % 16) begin n_err++; $display("FAIL rnd_waddr c=%0d got %0d exp %0d", c, waddr, wcnt % 16); end
      $display("random cycle %0d: we=%b acc=%b occ=%0d level=%0d full=%b", c, wr_en, acc, wcnt - rtrue, wr_level, full);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_release();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
